// File: rtl/datamem_con_arb_pkg.sv
// rtl/datamem_con_arb_pkg.sv - shared FSM encoding, byte-enable set and address window defaults
package datamem_con_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] BE_READ    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    localparam logic [9:0] WIN_LO_DEF = 10'h200;
    localparam logic [9:0] WIN_HI_DEF = 10'h3FF;

    // Only naturally aligned byte, halfword and word lanes reach the memory.
    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            BE_READ, BE_WORD, BE_HALF_LO, BE_HALF_HI,
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: be_legal = 1'b1;
            default:                                be_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/datamem_con_arb_rr_pick.sv
// rtl/datamem_con_arb_rr_pick.sv - combinational round-robin selector starting after the last grant
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    // Candidate distance k walks last+1 .. last+NREQ, so the previous winner is tried last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!o_any && i_valid[i] && (i == ((int'(i_last) + k) % NREQ))) begin
                    o_any      = 1'b1;
                    o_grant[i] = 1'b1;
                    o_idx      = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/datamem_con_arb.sv
// rtl/datamem_con_arb.sv - round-robin arbiter giving protocol controllers access to datamem port B
module datamem_con_arb
    import datamem_con_arb_pkg::*;
#(
    parameter int         NREQ   = 3,
    parameter logic [9:0] WIN_LO = WIN_LO_DEF,
    parameter logic [9:0] WIN_HI = WIN_HI_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_we,
    input  logic [10*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ-1:0]      rsp_err,
    output logic [31:0]          rsp_rdata,
    output logic [3:0]           con_write,
    output logic [9:0]           con_addr,
    output logic [31:0]          con_in,
    input  logic [31:0]          con_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_last_grant;
    logic [IW-1:0] r_win;
    logic [3:0]    r_we;
    logic [9:0]    r_addr;
    logic [31:0]   r_wdata;
    logic          r_illegal;
    logic [31:0]   r_rdata;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic [3:0]      w_sel_we;
    logic [9:0]      w_sel_addr;
    logic [31:0]     w_sel_wdata;
    logic            w_sel_illegal;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_valid (req_valid),
        .i_last  (r_last_grant),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_we    = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = req_we[4*i +: 4];
                w_sel_addr  = req_addr[10*i +: 10];
                w_sel_wdata = req_wdata[32*i +: 32];
            end
        end
    end

    // Widened compare keeps the upper window check meaningful when WIN_HI is the top address.
    assign w_sel_illegal = ({1'b0, w_sel_addr} < {1'b0, WIN_LO}) ||
                           ({1'b0, w_sel_addr} > {1'b0, WIN_HI}) ||
                           !be_legal(w_sel_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = w_any ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = '0;
        rsp_rdata = '0;
        con_write = '0;
        con_addr  = '0;
        con_in    = '0;
        if (!rst) begin
            rsp_rdata = r_rdata;
            case (r_state)
                ST_IDLE: begin
                    req_ready = w_grant;
                end
                ST_ACCESS: begin
                    con_addr  = r_addr;
                    con_in    = r_wdata;
                    con_write = r_illegal ? 4'b0000 : r_we;
                end
                ST_RESP: begin
                    rsp_valid[r_win] = 1'b1;
                    rsp_err[r_win]   = r_illegal;
                end
                default: ;
            endcase
        end
    end

    // Port B is clocked on ~clk, so con_out already holds the addressed word at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IW'(NREQ - 1);
            r_win        <= '0;
            r_we         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_illegal    <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_last_grant <= w_idx;
                r_win        <= w_idx;
                r_we         <= w_sel_we;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
                r_illegal    <= w_sel_illegal;
            end
            if (r_state == ST_ACCESS) begin
                r_rdata <= r_illegal ? 32'h0 : con_out;
            end
        end
    end

endmodule

// File: tb/tb_datamem_con_arb.sv
// tb/tb_datamem_con_arb.sv - scoreboard bench for datamem_con_arb with a negedge port-B memory model
module tb_datamem_con_arb;

    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [4*NREQ-1:0]    req_we;
    logic [10*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_err;
    logic [31:0]          rsp_rdata;
    logic [3:0]           con_write;
    logic [9:0]           con_addr;
    logic [31:0]          con_in;
    logic [31:0]          con_out = 32'h0;

    logic [31:0] mem [1024];

    typedef struct {
        int          idx;
        logic [3:0]  cw;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } txn_t;

    txn_t q_gnt[$];
    txn_t q_acc[$];
    txn_t q_rsp[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int g_cyc = 0;
    logic [3:0] prev_cw = 4'h0;

    datamem_con_arb #(
        .NREQ   (NREQ),
        .WIN_LO (10'h200),
        .WIN_HI (10'h3FF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .con_write (con_write),
        .con_addr  (con_addr),
        .con_in    (con_in),
        .con_out   (con_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        con_out <= mem[con_addr];
        for (int b = 0; b < 4; b++) begin
            if (con_write[b]) mem[con_addr][8*b +: 8] <= con_in[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        txn_t t;
        logic [NREQ-1:0] oh;
        if (req_ready != '0) begin
            if (q_gnt.size() == 0) begin
                chk("unexpected_grant", req_ready, 0);
            end else begin
                t = q_gnt.pop_front();
                oh = '0;
                oh[t.idx] = 1'b1;
                chk("grant", req_ready, oh);
                g_cyc = cyc;
                q_acc.push_back(t);
            end
        end
        if (con_addr != '0 || con_write != '0 || con_in != '0) begin
            if (q_acc.size() == 0) begin
                chk("unexpected_access", {con_write, con_addr, con_in}, 0);
            end else begin
                t = q_acc.pop_front();
                chk("acc_addr", con_addr, t.addr);
                chk("acc_write", con_write, t.cw);
                chk("acc_wdata", con_in, t.wd);
                chk("acc_latency", cyc - g_cyc, 1);
                q_rsp.push_back(t);
            end
        end
        if (prev_cw != '0 && con_write != '0) chk("write_repeated", con_write, 0);
        prev_cw = con_write;
        if (rsp_valid != '0) begin
            if (q_rsp.size() == 0) begin
                chk("unexpected_rsp", rsp_valid, 0);
            end else begin
                t = q_rsp.pop_front();
                oh = '0;
                oh[t.idx] = 1'b1;
                chk("rsp_valid", rsp_valid, oh);
                chk("rsp_err", rsp_err, t.err ? oh : '0);
                chk("rsp_rdata", rsp_rdata, t.rd);
                chk("rsp_latency", cyc - g_cyc, 2);
            end
        end
    end

    task automatic set_req(input int r, input logic [3:0] we, input logic [9:0] a,
                           input logic [31:0] wd, input logic err, input logic [31:0] rd);
        txn_t t;
        t.idx  = r;
        t.cw   = err ? 4'b0000 : we;
        t.addr = a;
        t.wd   = wd;
        t.err  = err;
        t.rd   = rd;
        q_gnt.push_back(t);
        req_we[4*r +: 4]     = we;
        req_addr[10*r +: 10] = a;
        req_wdata[32*r +: 32] = wd;
        req_valid[r]         = 1'b1;
    endtask

    task automatic run_grants(input int n, input bit drop);
        int last_c;
        bit timed_out;
        last_c    = 0;
        timed_out = 1'b0;
        for (int k = 0; k < n && !timed_out; k++) begin
            int w;
            logic [NREQ-1:0] g;
            w = 0;
            g = '0;
            while (g == '0 && w < 30) begin
                @(negedge clk);
                g = req_ready;
                w++;
            end
            if (g == '0) begin
                total++;
                bad++;
                $display("FAIL grant_timeout: no req_ready within 30 cycles (grant %0d of %0d)", k, n);
                timed_out = 1'b1;
            end else begin
                if (k > 0) chk("grant_gap", cyc - last_c, 3);
                last_c = cyc;
                if (drop) begin
                    @(posedge clk);
                    #1 req_valid &= ~g;
                end
            end
        end
        if (!drop || timed_out) begin
            @(posedge clk);
            #1 req_valid = '0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        @(negedge clk);
        chk(nm, {req_ready, rsp_valid, rsp_err, con_write, con_addr, con_in, rsp_rdata}, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h210] = 32'hCAFE0001;
        mem[10'h300] = 32'h11223344;
        mem[10'h301] = 32'h12345678;
        mem[10'h3FF] = 32'hA5A5A5A5;
        mem[10'h200] = 32'h55555555;
        mem[10'h220] = 32'h000000A0;
        mem[10'h221] = 32'h000000A1;
        mem[10'h222] = 32'h000000A2;

        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        chk_zero("reset_outputs");
        rst = 1'b0;
        chk_zero("idle_outputs");

        // single read
        set_req(1, 4'b0000, 10'h210, 32'h0, 1'b0, 32'hCAFE0001);
        run_grants(1, 1'b1);

        // byte write is read-first, then read back merged word
        set_req(0, 4'b0100, 10'h300, 32'h00AB0000, 1'b0, 32'h11223344);
        run_grants(1, 1'b1);
        set_req(0, 4'b0000, 10'h300, 32'h0, 1'b0, 32'h11AB3344);
        run_grants(1, 1'b1);

        // halfword and full word at the top of the window
        set_req(1, 4'b1100, 10'h301, 32'hCAFE0000, 1'b0, 32'h12345678);
        run_grants(1, 1'b1);
        set_req(2, 4'b0000, 10'h301, 32'h0, 1'b0, 32'hCAFE5678);
        run_grants(1, 1'b1);
        set_req(2, 4'b1111, 10'h3FF, 32'hDEADBEEF, 1'b0, 32'hA5A5A5A5);
        run_grants(1, 1'b1);
        set_req(1, 4'b0000, 10'h3FF, 32'h0, 1'b0, 32'hDEADBEEF);
        run_grants(1, 1'b1);

        // illegal address and illegal byte enables leave memory untouched
        set_req(1, 4'b0000, 10'h1FF, 32'h0, 1'b1, 32'h0);
        run_grants(1, 1'b1);
        set_req(1, 4'b0110, 10'h200, 32'hFFFFFFFF, 1'b1, 32'h0);
        run_grants(1, 1'b1);
        set_req(0, 4'b0101, 10'h3FF, 32'h00000001, 1'b1, 32'h0);
        run_grants(1, 1'b1);
        set_req(2, 4'b0000, 10'h200, 32'h0, 1'b0, 32'h55555555);
        run_grants(1, 1'b1);
        set_req(2, 4'b0000, 10'h3FF, 32'h0, 1'b0, 32'hDEADBEEF);
        run_grants(1, 1'b1);

        // fairness from reset: 0,1,2,0,1,2 three cycles apart
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            set_req(0, 4'b0000, 10'h220, 32'h0, 1'b0, 32'h000000A0);
            set_req(1, 4'b0000, 10'h221, 32'h0, 1'b0, 32'h000000A1);
            set_req(2, 4'b0000, 10'h222, 32'h0, 1'b0, 32'h000000A2);
        end
        run_grants(6, 1'b0);

        // after a grant to 0, requester 2 outranks requester 0
        set_req(0, 4'b0000, 10'h220, 32'h0, 1'b0, 32'h000000A0);
        run_grants(1, 1'b1);
        set_req(2, 4'b0000, 10'h222, 32'h0, 1'b0, 32'h000000A2);
        set_req(0, 4'b0000, 10'h221, 32'h0, 1'b0, 32'h000000A1);
        run_grants(2, 1'b1);

        // reset during RESP of a read by requester 2
        set_req(2, 4'b0000, 10'h210, 32'h0, 1'b0, 32'hCAFE0001);
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        chk_zero("rst_in_resp_outputs");
        rst = 1'b0;
        q_gnt.delete();
        q_acc.delete();
        q_rsp.delete();
        chk_zero("after_rst_outputs");
        set_req(0, 4'b0000, 10'h220, 32'h0, 1'b0, 32'h000000A0);
        set_req(2, 4'b0000, 10'h221, 32'h0, 1'b0, 32'h000000A1);
        run_grants(2, 1'b1);

        // reset during ACCESS after a grant to 0 must restore requester 0 priority
        set_req(0, 4'b0000, 10'h220, 32'h0, 1'b0, 32'h000000A0);
        run_grants(1, 1'b1);
        set_req(0, 4'b0000, 10'h222, 32'h0, 1'b0, 32'h000000A2);
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = '0;
        rst = 1'b1;
        chk_zero("rst_in_access_outputs");
        rst = 1'b0;
        q_gnt.delete();
        q_acc.delete();
        q_rsp.delete();
        set_req(0, 4'b0000, 10'h220, 32'h0, 1'b0, 32'h000000A0);
        set_req(1, 4'b0000, 10'h222, 32'h0, 1'b0, 32'h000000A2);
        run_grants(2, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", q_gnt.size() + q_acc.size() + q_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
